multicycle_control_fsm: RTL and testbench

- Sequencing controller for the multi-cycle RISC-V core. Replaces single-cycle per-opcode decode with a state machine.
- Drives PC/IR enables, ALU operand selects, shared instruction/data memory handshake and register-file writeback across FETCH/DECODE/EXEC/MEM/WB.
- Sits between the IR opcode field, the shared memory port and the datapath mux/enable controls.

---
 rtl/multicycle_control_fsm_if.sv | 10 +
 rtl/multicycle_control_fsm.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Shared instruction/data memory handshake between the control FSM and the memory port.
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V sequencing controller: FETCH/DECODE/EXEC/MEM/WB with
// memory wait timeout. Outputs are decoded combinationally from state and opcode.
module multicycle_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [6:0]                 opcode,
    input  logic                       branch_cond,
    multicycle_control_fsm_if.master   mem,
    output logic                       ir_write,
    output logic                       pc_write,
    output logic                       pc_src,
    output logic [1:0]                 alu_src_a,
    output logic [1:0]                 alu_src_b,
    output logic [1:0]                 alu_op,
    output logic                       reg_write,
    output logic                       mem_to_reg,
    output logic                       illegal_instr,
    output logic                       mem_timeout,
    output logic                       instret,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t           cur, nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_phase;
    logic             timeout_hit;
    logic             legal;

    assign mem_phase   = (cur == S_FETCH) || (cur == S_MEM);
    // Limit reached on the previous cycle: this cycle is spent signalling the timeout.
    assign timeout_hit = (WAIT_LIMIT != 0) && mem_phase && (wait_cnt == CNT_W'(WAIT_LIMIT));
    assign legal       = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                         (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign state       = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= S_RESET;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (mem_phase && !mem.mem_ready && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        nxt           = cur;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.iord      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = 1'b0;
        instret       = 1'b0;
        case (cur)
            S_RESET: nxt = S_FETCH;
            S_FETCH: begin
                if (timeout_hit) begin
                    mem_timeout = 1'b1;
                    nxt         = S_FETCH;
                end else begin
                    mem.mem_req = 1'b1;
                    alu_src_b   = 2'b01;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                if (legal) begin
                    nxt = S_EXEC;
                end else begin
                    illegal_instr = 1'b1;
                    nxt           = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 2'b01;
                nxt       = S_FETCH;
                case (opcode)
                    OP_R: begin
                        alu_op = 2'b10;
                        nxt    = S_WB;
                    end
                    OP_I: begin
                        alu_src_b = 2'b10;
                        alu_op    = 2'b10;
                        nxt       = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 2'b10;
                        nxt       = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = branch_cond;
                        instret  = 1'b1;
                    end
                    default: nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (timeout_hit) begin
                    // Abandon the access: no writeback, no retire.
                    mem_timeout = 1'b1;
                    nxt         = S_FETCH;
                end else begin
                    mem.mem_req = 1'b1;
                    mem.iord    = 1'b1;
                    mem.mem_we  = (opcode == OP_STORE);
                    if (mem.mem_ready) begin
                        if (opcode == OP_STORE) begin
                            instret = 1'b1;
                            nxt     = S_FETCH;
                        end else begin
                            nxt = S_WB;
                        end
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD);
                instret    = 1'b1;
                nxt        = S_FETCH;
            end
            default: nxt = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: instruction-level plans are expanded into per-cycle expected
// control vectors and compared against the controller every cycle.
module tb_multicycle_control_fsm;
    localparam int LIM = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mwe, iord, irw, pcw, pcs;
        logic [1:0] sa, sb, aop;
        logic       rw, m2r, ill, tmo, ret;
    } ovec_t;

    typedef struct packed {
        logic       rdy;
        logic       bc;
        logic [6:0] op;
        ovec_t      exp;
    } step_t;

    logic clk, rst_n;
    logic [6:0] opcode;
    logic branch_cond;
    logic ir_write, pc_write, pc_src, reg_write, mem_to_reg;
    logic illegal_instr, mem_timeout, instret;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [2:0] state;
    ovec_t got;

    multicycle_control_fsm_if mif();

    multicycle_control_fsm #(.WAIT_LIMIT(LIM), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond),
        .mem(mif), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
        .mem_timeout(mem_timeout), .instret(instret), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        got      = '0;
        got.st   = state;
        got.mreq = mif.mem_req;
        got.mwe  = mif.mem_we;
        got.iord = mif.iord;
        got.irw  = ir_write;
        got.pcw  = pc_write;
        got.pcs  = pc_src;
        got.sa   = alu_src_a;
        got.sb   = alu_src_b;
        got.aop  = alu_op;
        got.rw   = reg_write;
        got.m2r  = mem_to_reg;
        got.ill  = illegal_instr;
        got.tmo  = mem_timeout;
        got.ret  = instret;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    step_t q[$];
    logic [6:0] cur_op;
    logic       cur_bc;

    task automatic chk(input string tag, input ovec_t obs, input ovec_t exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (st %0d vs %0d)", tag, obs, exp, obs.st, exp.st);
        end
    endtask

    function automatic ovec_t blank(input logic [2:0] st);
        ovec_t v = '0;
        v.st = st;
        return v;
    endfunction

    task automatic push(input ovec_t e, input logic rdy);
        step_t s;
        s.rdy = rdy;
        s.bc  = cur_bc;
        s.op  = cur_op;
        s.exp = e;
        q.push_back(s);
    endtask

    function automatic ovec_t fetch_v(input logic done);
        ovec_t v = blank(3'd1);
        v.mreq = 1'b1;
        v.sb   = 2'b01;
        v.irw  = done;
        v.pcw  = done;
        return v;
    endfunction

    // Memory phase: w idle cycles before mem_ready; w >= LIM means the limit hits first.
    task automatic fetch_ph(input int wf);
        int w = wf;
        bit done = 0;
        while (!done) begin
            if (w >= LIM) begin
                repeat (LIM) push(fetch_v(1'b0), 1'b0);
                begin ovec_t t = blank(3'd1); t.tmo = 1'b1; push(t, 1'b0); end
                w = 0;
            end else begin
                repeat (w) push(fetch_v(1'b0), 1'b0);
                push(fetch_v(1'b1), 1'b1);
                done = 1;
            end
        end
    endtask

    task automatic mem_ph(input int wm, input bit is_st, output bit ok);
        ovec_t v = blank(3'd4);
        v.mreq = 1'b1;
        v.iord = 1'b1;
        v.mwe  = is_st;
        if (wm >= LIM) begin
            ovec_t t = blank(3'd4);
            t.tmo = 1'b1;
            repeat (LIM) push(v, 1'b0);
            push(t, 1'b0);
            ok = 0;
        end else begin
            repeat (wm) push(v, 1'b0);
            v.ret = is_st;
            push(v, 1'b1);
            ok = 1;
        end
    endtask

    task automatic add_instr(input logic [6:0] op, input int wf, input int wm, input logic bc);
        ovec_t v;
        bit ok;
        bit legal;
        cur_op = op;
        cur_bc = bc;
        legal = (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
                (op == 7'b0100011) || (op == 7'b1100011);
        fetch_ph(wf);
        v = blank(3'd2); v.sa = 2'b10; v.sb = 2'b10; v.ill = !legal;
        push(v, 1'($urandom_range(0, 1)));
        if (!legal) return;
        v = blank(3'd3); v.sa = 2'b01;
        case (op)
            7'b0110011: v.aop = 2'b10;
            7'b0010011: begin v.sb = 2'b10; v.aop = 2'b10; end
            7'b1100011: begin v.aop = 2'b01; v.pcs = 1'b1; v.pcw = bc; v.ret = 1'b1; end
            default:    v.sb = 2'b10;
        endcase
        push(v, 1'($urandom_range(0, 1)));
        if (op == 7'b1100011) return;
        if (op == 7'b0000011 || op == 7'b0100011) begin
            mem_ph(wm, op == 7'b0100011, ok);
            if (!ok || op == 7'b0100011) return;
        end
        v = blank(3'd5); v.rw = 1'b1; v.ret = 1'b1; v.m2r = (op == 7'b0000011);
        push(v, 1'($urandom_range(0, 1)));
    endtask

    task automatic run_q(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            step_t s = q.pop_front();
            @(posedge clk);
            #1;
            mif.mem_ready = s.rdy;
            branch_cond   = s.bc;
            opcode        = s.op;
            @(negedge clk);
            cyc++;
            chk($sformatf("cyc%0d", cyc), got, s.exp);
        end
    endtask

    function automatic int rnd_wait();
        int r = $urandom_range(0, 9);
        if (r < 6)  return $urandom_range(0, 3);
        if (r == 6) return LIM - 1;
        if (r == 7) return LIM;
        return 0;
    endfunction

    initial begin
        logic [6:0] ops [5];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;
        rst_n = 1'b0; mif.mem_ready = 1'b1; opcode = 7'b0110011; branch_cond = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", got, '0);
        rst_n = 1'b1;
        #1 chk("reset_state", got, blank(3'd0));

        add_instr(7'b0110011, 0, 0, 1'b0);   // R-type, no waits
        add_instr(7'b0000011, 0, 3, 1'b0);   // load, MEM held 4 cycles
        add_instr(7'b0100011, 0, 0, 1'b0);   // store
        add_instr(7'b1100011, 0, 0, 1'b0);   // branch not taken
        add_instr(7'b1100011, 0, 0, 1'b1);   // branch taken
        add_instr(7'b1111111, 0, 0, 1'b0);   // illegal
        add_instr(7'b0010011, LIM, 0, 1'b0); // fetch timeout then retry
        add_instr(7'b0010011, LIM - 1, 0, 1'b0);
        add_instr(7'b0000011, 0, LIM, 1'b0); // MEM timeout abandons load
        add_instr(7'b0100011, 0, LIM - 1, 1'b0);
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
            add_instr(op, rnd_wait(), rnd_wait(), 1'($urandom_range(0, 1)));
        end
        run_q(q.size());

        // Asynchronous reset in the middle of a store's MEM phase.
        add_instr(7'b0100011, 0, 10, 1'b0);
        run_q(5);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", got, '0);
        @(negedge clk);
        chk("rst_hold", got, '0);
        q.delete();
        rst_n = 1'b1;
        #1 chk("rst_release", got, blank(3'd0));
        add_instr(7'b0110011, 0, 0, 1'b0);
        run_q(q.size());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
